video_mono_tint: RTL and testbench

- Pipelined colour-to-monochrome video stage. It sits between the system video outputs (r/g/b, HSYNC, VSYNC, de) and the VGA_R/G/B/HS/VS/DE top-level ports.
- Generalises the combinational green/amber/B&W selector:
  - parametrised input and output channel widths;
  - registered 3-stage pipeline with sync/DE kept aligned;
  - a user-programmable custom tint;
  - mode/tint changes applied only at a frame boundary, so no mid-frame tearing.

---
 rtl/video_mono_tint_pkg.sv | 36 +++
 rtl/video_mono_tint_luma.sv | 59 +++++
 rtl/video_mono_tint.sv | 137 +++++++++++++
 tb/tb_video_mono_tint.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/video_mono_tint_pkg.sv
// Shared constants and types for the monochrome/tint video stage.
package video_mono_pkg;

   // Output modes; codes above MODE_TINT fall back to colour.
   localparam logic [2:0] MODE_COLOR = 3'd0;
   localparam logic [2:0] MODE_GREEN = 3'd1;
   localparam logic [2:0] MODE_AMBER = 3'd2;
   localparam logic [2:0] MODE_BW    = 3'd3;
   localparam logic [2:0] MODE_TINT  = 3'd4;

   // Luma weights, scaled so they sum to 256.
   localparam int COEF_R = 54;
   localparam int COEF_G = 183;
   localparam int COEF_B = 19;

   // Input sample to output pixel, in ce_pix-qualified cycles.
   localparam int PIPE_DEPTH = 3;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } tint_t;

   // Fold unused mode codes onto colour so mode_active reports what is applied.
   function automatic logic [2:0] norm_mode(input logic [2:0] m);
      return (m > MODE_TINT) ? MODE_COLOR : m;
   endfunction

endpackage

// File: rtl/video_mono_tint_luma.sv
// Luma path: stage 1 weighted products, stage 2 sum/shift and width expansion.
module mono_luma
   import video_mono_pkg::*;
#(
   parameter int IN_W  = 6,
   parameter int OUT_W = 8
) (
   input  logic                       clk_vga,
   input  logic                       reset,
   input  logic                       ce_pix,
   input  logic [2:0][IN_W-1:0]       rgb_in,   // [2]=R [1]=G [0]=B
   output logic [OUT_W-1:0]           y_exp,
   output logic [2:0][OUT_W-1:0]      rgb_exp
);

   localparam int PW = IN_W + 8;
   localparam int SW = IN_W + 10;

   logic [PW-1:0]         pr, pg, pb;
   logic [2:0][IN_W-1:0]  rgb_s1;
   logic [SW-1:0]         sum;
   logic [IN_W-1:0]       y;

   // Widen by repeating the MSBs so full scale maps to full scale.
   function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] v);
      return OUT_W'({v, v} >> (2*IN_W - OUT_W));
   endfunction

   // Coefficients sum to 256, so the shifted sum never exceeds IN_W bits.
   assign sum = SW'(pr) + SW'(pg) + SW'(pb);
   assign y   = IN_W'(sum >> 8);

   // Stage 1: weighted products plus raw channels for colour mode.
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         pr     <= '0;
         pg     <= '0;
         pb     <= '0;
         rgb_s1 <= '0;
      end else if (ce_pix) begin
         pr     <= PW'(COEF_R) * PW'(rgb_in[2]);
         pg     <= PW'(COEF_G) * PW'(rgb_in[1]);
         pb     <= PW'(COEF_B) * PW'(rgb_in[0]);
         rgb_s1 <= rgb_in;
      end
   end

   // Stage 2: luma and raw channels expanded to the output width.
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         y_exp   <= '0;
         rgb_exp <= '0;
      end else if (ce_pix) begin
         y_exp <= expand(y);
         for (int i = 0; i < 3; i++) rgb_exp[i] <= expand(rgb_s1[i]);
      end
   end

endmodule

// File: rtl/video_mono_tint.sv
// Colour-to-monochrome/tint video stage with frame-synchronous mode changes.
module video_mono_tint
   import video_mono_pkg::*;
#(
   parameter int IN_W   = 6,
   parameter int OUT_W  = 8,
   parameter bit VS_POL = 1'b1
) (
   input  logic              clk_vga,
   input  logic              reset,
   input  logic              ce_pix,
   input  logic [2:0]        mode,
   input  logic [7:0]        tint_r,
   input  logic [7:0]        tint_g,
   input  logic [7:0]        tint_b,
   input  logic [IN_W-1:0]   r_in,
   input  logic [IN_W-1:0]   g_in,
   input  logic [IN_W-1:0]   b_in,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              de_in,
   output logic [OUT_W-1:0]  r_out,
   output logic [OUT_W-1:0]  g_out,
   output logic [OUT_W-1:0]  b_out,
   output logic              hs_out,
   output logic              vs_out,
   output logic              de_out,
   output logic [2:0]        mode_active
);

   // Shift amounts between OUT_W and the 8-bit tint multiplier domain.
   localparam int DN = (OUT_W > 8)  ? OUT_W - 8  : 0;
   localparam int UP = (OUT_W >= 8) ? 16 - OUT_W : 0;

   logic                    vs_prev, vs_start;
   tint_t                   tint_in, tint_sh, tint_cur, tint_s1, tint_s2;
   logic [2:0]              mode_cur, mode_s1, mode_s2;
   sync_t                   sync_in;
   sync_t [PIPE_DEPTH-1:0]  sync_pipe;
   logic [OUT_W-1:0]        y_exp;
   logic [2:0][OUT_W-1:0]   rgb_exp, pix_mux, rgb_q;

   // Scale luma by (tint+1)/256 in 8 bits, then return to OUT_W.
   function automatic logic [OUT_W-1:0] tint_ch(input logic [OUT_W-1:0] yv,
                                                input logic [7:0] t);
      logic [7:0]  y8, res8;
      logic [16:0] prod;
      y8   = 8'(yv >> DN);
      prod = 17'(y8) * (17'(t) + 17'd1);
      res8 = 8'(prod >> 8);
      return OUT_W'({res8, res8} >> UP);
   endfunction

   assign tint_in  = '{r: tint_r, g: tint_g, b: tint_b};
   assign sync_in  = '{hs: hs_in, vs: vs_in, de: de_in};
   assign vs_start = ce_pix & (vs_in == VS_POL) & (vs_prev != VS_POL);

   // The pixel sampled on the frame edge already uses the new settings.
   assign mode_cur = vs_start ? norm_mode(mode) : mode_active;
   assign tint_cur = vs_start ? tint_in : tint_sh;

   // Frame-boundary latch of mode and tint.
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         vs_prev     <= 1'b0;
         mode_active <= MODE_COLOR;
         tint_sh     <= '0;
      end else if (ce_pix) begin
         vs_prev <= vs_in;
         if (vs_start) begin
            mode_active <= norm_mode(mode);
            tint_sh     <= tint_in;
         end
      end
   end

   // Mode/tint travel with the pixel; sync/DE delay line matches the latency.
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         mode_s1   <= MODE_COLOR;
         mode_s2   <= MODE_COLOR;
         tint_s1   <= '0;
         tint_s2   <= '0;
         sync_pipe <= '0;
      end else if (ce_pix) begin
         mode_s1   <= mode_cur;
         mode_s2   <= mode_s1;
         tint_s1   <= tint_cur;
         tint_s2   <= tint_s1;
         sync_pipe <= {sync_pipe[PIPE_DEPTH-2:0], sync_in};
      end
   end

   mono_luma #(.IN_W(IN_W), .OUT_W(OUT_W)) u_luma (
      .clk_vga (clk_vga),
      .reset   (reset),
      .ce_pix  (ce_pix),
      .rgb_in  ({r_in, g_in, b_in}),
      .y_exp   (y_exp),
      .rgb_exp (rgb_exp)
   );

   // Stage-3 output mux selected by the mode carried with this pixel.
   always_comb begin
      pix_mux = '0;
      case (mode_s2)
         MODE_GREEN: pix_mux[1] = y_exp;
         MODE_AMBER: begin
            pix_mux[2] = y_exp;
            pix_mux[1] = y_exp >> 1;
         end
         MODE_BW:    pix_mux = {y_exp, y_exp, y_exp};
         MODE_TINT: begin
            pix_mux[2] = tint_ch(y_exp, tint_s2.r);
            pix_mux[1] = tint_ch(y_exp, tint_s2.g);
            pix_mux[0] = tint_ch(y_exp, tint_s2.b);
         end
         default:    pix_mux = rgb_exp;
      endcase
   end

   // Stage 3: register the pixel, blanked outside active video.
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset)
         rgb_q <= '0;
      else if (ce_pix)
         rgb_q <= sync_pipe[PIPE_DEPTH-2].de ? pix_mux : '0;
   end

   assign r_out  = rgb_q[2];
   assign g_out  = rgb_q[1];
   assign b_out  = rgb_q[0];
   assign hs_out = sync_pipe[PIPE_DEPTH-1].hs;
   assign vs_out = sync_pipe[PIPE_DEPTH-1].vs;
   assign de_out = sync_pipe[PIPE_DEPTH-1].de;

endmodule

// File: tb/tb_video_mono_tint.sv
// Directed bench for video_mono_tint at IN_W=6, OUT_W=8, active-high VSYNC.
module tb_video_mono_tint;

   logic       clk_vga = 1'b0;
   logic       reset, ce_pix;
   logic [2:0] mode;
   logic [7:0] tint_r, tint_g, tint_b;
   logic [5:0] r_in, g_in, b_in;
   logic       hs_in, vs_in, de_in;
   logic [7:0] r_out, g_out, b_out;
   logic       hs_out, vs_out, de_out;
   logic [2:0] mode_active;

   int checks = 0;
   int failures = 0;

   video_mono_tint #(.IN_W(6), .OUT_W(8), .VS_POL(1'b1)) dut (
      .clk_vga     (clk_vga),
      .reset       (reset),
      .ce_pix      (ce_pix),
      .mode        (mode),
      .tint_r      (tint_r),
      .tint_g      (tint_g),
      .tint_b      (tint_b),
      .r_in        (r_in),
      .g_in        (g_in),
      .b_in        (b_in),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .de_in       (de_in),
      .r_out       (r_out),
      .g_out       (g_out),
      .b_out       (b_out),
      .hs_out      (hs_out),
      .vs_out      (vs_out),
      .de_out      (de_out),
      .mode_active (mode_active)
   );

   always #5 clk_vga = ~clk_vga;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic chk_px(input string tag, input logic [7:0] er, input logic [7:0] eg,
                         input logic [7:0] eb, input logic ede);
      chk({tag, ".r"},  r_out,  er);
      chk({tag, ".g"},  g_out,  eg);
      chk({tag, ".b"},  b_out,  eb);
      chk({tag, ".de"}, de_out, ede);
   endtask

   // Apply one input sample, clock it, and settle just after the edge.
   task automatic push(input logic c, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b, input logic h, input logic v, input logic d);
      ce_pix = c; r_in = r; g_in = g; b_in = b; hs_in = h; vs_in = v; de_in = d;
      @(posedge clk_vga);
      #1;
   endtask

   // Start a new frame with the given mode/tint (VSYNC pulse, then inactive).
   task automatic frame(input logic [2:0] m, input logic [7:0] tr, input logic [7:0] tg,
                        input logic [7:0] tb);
      mode = m; tint_r = tr; tint_g = tg; tint_b = tb;
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // One active pixel followed by two blanks; afterwards the output shows it.
   task automatic pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
      push(1'b1, r, g, b, 1'b0, 1'b0, 1'b1);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // ce-qualified pixel, output check, two ce-low cycles of junk, hold check.
   task automatic cpix(input string tag, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b, input logic d, input logic [7:0] er,
                       input logic [7:0] eg, input logic [7:0] eb, input logic ede);
      push(1'b1, r, g, b, 1'b0, 1'b0, d);
      chk_px({tag, ".ce"}, er, eg, eb, ede);
      push(1'b0, 6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b1);
      push(1'b0, 6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b1);
      chk_px({tag, ".hold"}, er, eg, eb, ede);
      chk({tag, ".hold.hs"}, hs_out, 1'b0);
   endtask

   initial begin
      reset = 1'b1; ce_pix = 1'b1; mode = 3'd0;
      tint_r = 8'd0; tint_g = 8'd0; tint_b = 8'd0;
      r_in = '0; g_in = '0; b_in = '0; hs_in = 0; vs_in = 0; de_in = 0;
      repeat (3) @(posedge clk_vga);
      #1;
      chk_px("reset", 8'h00, 8'h00, 8'h00, 1'b0);
      chk("reset.hs", hs_out, 1'b0);
      chk("reset.vs", vs_out, 1'b0);
      chk("reset.mode", mode_active, 3'd0);
      reset = 1'b0;

      // B&W full white, with exact 3-cycle sync alignment.
      mode = 3'd3;
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
      push(1'b1, 6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b1);
      chk("t1.d1.de", de_out, 1'b0);
      chk("t1.d1.vs", vs_out, 1'b0);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      chk("t1.d3.vs", vs_out, 1'b1);
      chk("t1.d3.hs", hs_out, 1'b0);
      chk("t1.mode", mode_active, 3'd3);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      chk_px("t1.white", 8'hFF, 8'hFF, 8'hFF, 1'b1);
      chk("t1.hs", hs_out, 1'b1);
      chk("t1.vs_off", vs_out, 1'b0);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      chk_px("t1.after", 8'h00, 8'h00, 8'h00, 1'b0);
      chk("t1.after.hs", hs_out, 1'b0);

      // Green and amber luma.
      frame(3'd1, 8'd0, 8'd0, 8'd0);
      pix(6'd63, 6'd0, 6'd0);
      chk_px("t2.green", 8'h00, 8'h34, 8'h00, 1'b1);
      frame(3'd2, 8'd0, 8'd0, 8'd0);
      pix(6'd0, 6'd63, 6'd0);
      chk_px("t2.amber", 8'hB6, 8'h5B, 8'h00, 1'b1);

      // Custom tint; a mid-frame tint change must not take effect.
      frame(3'd4, 8'h80, 8'hFF, 8'h00);
      chk("t3.mode", mode_active, 3'd4);
      pix(6'd63, 6'd63, 6'd63);
      chk_px("t3.tint", 8'h80, 8'hFF, 8'h00, 1'b1);
      frame(3'd4, 8'h00, 8'h00, 8'h00);
      pix(6'd63, 6'd63, 6'd63);
      chk_px("t3.zero", 8'h00, 8'h00, 8'h00, 1'b1);
      tint_r = 8'hFF; tint_g = 8'hFF; tint_b = 8'hFF;
      pix(6'd63, 6'd63, 6'd63);
      chk_px("t3.midtint", 8'h00, 8'h00, 8'h00, 1'b1);

      // Colour, then green requested mid-frame, applied from the VSYNC edge.
      frame(3'd0, 8'd0, 8'd0, 8'd0);
      pix(6'd63, 6'd0, 6'd32);
      chk_px("t4.color", 8'hFF, 8'h00, 8'h82, 1'b1);
      mode = 3'd1;
      pix(6'd63, 6'd0, 6'd32);
      chk_px("t4.midframe", 8'hFF, 8'h00, 8'h82, 1'b1);
      chk("t4.mode_hold", mode_active, 3'd0);
      push(1'b1, 6'd63, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
      chk("t4.mode_new", mode_active, 3'd1);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      push(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      chk_px("t4.edge_px", 8'h00, 8'h34, 8'h00, 1'b1);
      pix(6'd0, 6'd63, 6'd0);
      chk_px("t4.next_px", 8'h00, 8'hB6, 8'h00, 1'b1);

      // ce_pix 1-of-3 with a blanked pixel in the stream.
      frame(3'd0, 8'd0, 8'd0, 8'd0);
      cpix("t5.a", 6'd10, 6'd20, 6'd30, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      cpix("t5.b", 6'd63, 6'd63, 6'd63, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      cpix("t5.c", 6'd5,  6'd5,  6'd5,  1'b1, 8'h28, 8'h51, 8'h79, 1'b1);
      cpix("t5.d", 6'd0,  6'd0,  6'd0,  1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      cpix("t5.e", 6'd0,  6'd0,  6'd0,  1'b0, 8'h14, 8'h14, 8'h14, 1'b1);

      // Reset mid-line with B&W data in flight.
      frame(3'd3, 8'd0, 8'd0, 8'd0);
      push(1'b1, 6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b1);
      push(1'b1, 6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b1);
      push(1'b1, 6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b1);
      chk_px("t6.pre", 8'hFF, 8'hFF, 8'hFF, 1'b1);
      reset = 1'b1;
      #1;
      chk_px("t6.async", 8'h00, 8'h00, 8'h00, 1'b0);
      chk("t6.async.hs", hs_out, 1'b0);
      chk("t6.async.mode", mode_active, 3'd0);
      @(posedge clk_vga);
      #1;
      reset = 1'b0;
      push(1'b1, 6'd63, 6'd0, 6'd32, 1'b1, 1'b0, 1'b1);
      chk_px("t6.z1", 8'h00, 8'h00, 8'h00, 1'b0);
      chk("t6.z1.hs", hs_out, 1'b0);
      push(1'b1, 6'd63, 6'd0, 6'd32, 1'b1, 1'b0, 1'b1);
      chk_px("t6.z2", 8'h00, 8'h00, 8'h00, 1'b0);
      push(1'b1, 6'd63, 6'd0, 6'd32, 1'b1, 1'b0, 1'b1);
      chk_px("t6.color", 8'hFF, 8'h00, 8'h82, 1'b1);
      chk("t6.hs", hs_out, 1'b1);
      chk("t6.mode", mode_active, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
